// File: rtl/axivideo_patgen_if.sv
`default_nettype none
// ============================================================================
//  Module      : axivideo_patgen_if
//  Description : AXI-stream video bus (TVALID/TREADY/TDATA/TLAST/TUSER)
//                shared by the pattern generator and its consumer.
//  Revision    : 1.0  initial release
// ============================================================================
interface axivideo_patgen_if #(
    parameter int PW = 24
) ();
    logic          TVALID;
    logic          TREADY;
    logic [PW-1:0] TDATA;
    logic          TLAST;
    logic          TUSER;

    modport master (output TVALID, output TDATA, output TLAST, output TUSER,
                    input  TREADY);
    modport slave  (input  TVALID, input  TDATA, input  TLAST, input  TUSER,
                    output TREADY);
endinterface
`default_nettype wire

// File: rtl/axivideo_patgen.sv
`default_nettype none
// ============================================================================
//  Module      : axivideo_patgen
//  Description : Synthetic AXI-stream video source. Emits fixed-geometry
//                frames (x ramp, y ramp, checkerboard, frame counter) with
//                all outputs registered and held stable under back-pressure.
//  Options     : define AXIVIDEO_PATGEN_FRMCNT_EN to build the 16-bit
//                completed-frame counter (pattern 3 then shows its low byte;
//                otherwise pattern 3 is constant 8'h80 and the count is 0).
//  Revision    : 1.0  initial release
// ============================================================================
module axivideo_patgen #(
    parameter int PW               = 24,
    parameter int LGDIM            = 10,
    parameter bit OPT_TUSER_IS_SOF = 1'b1
) (
    input  wire                 i_clk,
    input  wire                 i_reset_n,
    input  wire                 i_en,
    input  wire [LGDIM-1:0]     i_width,
    input  wire [LGDIM-1:0]     i_height,
    input  wire [1:0]           i_pattern,
    axivideo_patgen_if.master   M_VID,
    output logic                o_busy,
    output logic                o_frame_done,
    output logic [15:0]         o_frame_count
);
    localparam int               c_lanes = PW / 8;
    localparam logic [LGDIM-1:0] c_one   = LGDIM'(1);
    localparam logic [LGDIM-1:0] c_two   = LGDIM'(2);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [LGDIM-1:0]  xpos_q, xpos_d, ypos_q, ypos_d;
    logic [LGDIM-1:0]  width_q, width_d, height_q, height_d;
    logic [1:0]        pattern_q, pattern_d;
    logic              tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
    logic [PW-1:0]     tdata_q, tdata_d;
    logic              done_q, done_d;

    logic              w_xfer, w_dims_ok, w_at_eol, w_last_px;
    logic              w_load, w_stop;
    logic [7:0]        w_pix;

    // TVALID is only ever high in ACTIVE, so a transfer implies ACTIVE.
    assign w_xfer    = tvalid_q && M_VID.TREADY;
    assign w_dims_ok = (i_width > c_two) && (i_height > c_two);
    assign w_at_eol  = (xpos_q == width_q - c_one);
    assign w_last_px = w_at_eol && (ypos_q == height_q - c_one);

`ifdef AXIVIDEO_PATGEN_FRMCNT_EN
    logic [15:0] fcnt_q, fcnt_d;

    // Count completed frames; the next frame already sees the new count.
    always_comb begin
        fcnt_d = fcnt_q;
        if (w_xfer && w_last_px) begin
            fcnt_d = fcnt_q + 16'd1;
        end
    end

    // Frame counter register, cleared only by reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            fcnt_q <= 16'h0000;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    assign o_frame_count = fcnt_q;
`else
    assign o_frame_count = 16'h0000;
`endif

    // Next-state and position sequencing; dims/pattern latched at frame start.
    always_comb begin
        state_d   = state_q;
        xpos_d    = xpos_q;
        ypos_d    = ypos_q;
        width_d   = width_q;
        height_d  = height_q;
        pattern_d = pattern_q;
        done_d    = 1'b0;
        w_load    = 1'b0;
        w_stop    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_en && w_dims_ok) begin
                    state_d   = S_ACTIVE;
                    width_d   = i_width;
                    height_d  = i_height;
                    pattern_d = i_pattern;
                    xpos_d    = '0;
                    ypos_d    = '0;
                    w_load    = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (w_xfer) begin
                    w_load = 1'b1;
                    if (w_last_px) begin
                        done_d = 1'b1;
                        xpos_d = '0;
                        ypos_d = '0;
                        if (i_en && w_dims_ok) begin
                            width_d   = i_width;
                            height_d  = i_height;
                            pattern_d = i_pattern;
                        end else begin
                            state_d = S_IDLE;
                            w_load  = 1'b0;
                            w_stop  = 1'b1;
                        end
                    end else if (w_at_eol) begin
                        xpos_d = '0;
                        ypos_d = ypos_q + c_one;
                    end else begin
                        xpos_d = xpos_q + c_one;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered beat contents for the pixel about to be presented.
    always_comb begin
        w_pix = 8'h00;
        case (pattern_d)
            2'd0: w_pix = xpos_d[7:0];
            2'd1: w_pix = ypos_d[7:0];
            2'd2: w_pix = (xpos_d[3] ^ ypos_d[3]) ? 8'hFF : 8'h00;
`ifdef AXIVIDEO_PATGEN_FRMCNT_EN
            default: w_pix = fcnt_d[7:0];
`else
            default: w_pix = 8'h80;
`endif
        endcase

        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        tuser_d  = tuser_q;
        if (w_load) begin
            tvalid_d = 1'b1;
            tdata_d  = {c_lanes{w_pix}};
            if (OPT_TUSER_IS_SOF) begin
                tlast_d = (xpos_d == width_d - c_one);
                tuser_d = (xpos_d == '0) && (ypos_d == '0);
            end else begin
                tlast_d = (xpos_d == width_d - c_one) && (ypos_d == height_d - c_one);
                tuser_d = (xpos_d == width_d - c_one);
            end
        end else if (w_stop) begin
            tvalid_d = 1'b0;
            tdata_d  = '0;
            tlast_d  = 1'b0;
            tuser_d  = 1'b0;
        end
    end

    // State, position and output registers.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q   <= S_IDLE;
            xpos_q    <= '0;
            ypos_q    <= '0;
            width_q   <= '0;
            height_q  <= '0;
            pattern_q <= 2'd0;
            tvalid_q  <= 1'b0;
            tdata_q   <= '0;
            tlast_q   <= 1'b0;
            tuser_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            xpos_q    <= xpos_d;
            ypos_q    <= ypos_d;
            width_q   <= width_d;
            height_q  <= height_d;
            pattern_q <= pattern_d;
            tvalid_q  <= tvalid_d;
            tdata_q   <= tdata_d;
            tlast_q   <= tlast_d;
            tuser_q   <= tuser_d;
            done_q    <= done_d;
        end
    end

    assign M_VID.TVALID = tvalid_q;
    assign M_VID.TDATA  = tdata_q;
    assign M_VID.TLAST  = tlast_q;
    assign M_VID.TUSER  = tuser_q;
    assign o_busy       = (state_q == S_ACTIVE);
    assign o_frame_done = done_q;

endmodule
`default_nettype wire
